// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM states and access size/mask helpers for the LSU.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, FIRST, SECOND, DONE, ERR} state_t;

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    endfunction

    function automatic logic [3:0] f3_mask(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (!we && (f3 == F3_BU || f3 == F3_HU));
    endfunction
endpackage

// File: rtl/lsu_extract.sv
// lsu_extract: picks the addressed bytes out of a 64-bit load window and sign/zero-extends them.
module lsu_extract
    import lsu_pkg::*;
(
    input  logic [63:0] i_window,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_shift;
    assign w_shift = 32'(i_window >> {i_offset, 3'b000});
    assign o_data = i_funct3 == F3_B  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                    i_funct3 == F3_BU ? {24'b0, w_shift[7:0]} :
                    i_funct3 == F3_H  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                    i_funct3 == F3_HU ? {16'b0, w_shift[15:0]} : w_shift;
endmodule

// File: rtl/lsu_align.sv
// lsu_align: byte-aligned load/store unit; misaligned accesses crossing a word become two word accesses.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_funct3,
    output logic                     rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [3:0]               mem_be,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_we;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [2:0]               r_f3;
    logic [DATA_WIDTH-1:0]    r_lo_word;
    logic                     w_first, w_second, w_split;
    logic [5:0]               w_shamt;
    logic [63:0]              w_wdata_win, w_window;
    logic [7:0]               w_be_win;
    logic [ADDRESS_WIDTH-1:0] w_base;
    logic [31:0]              w_load;

    assign w_first     = r_state == FIRST;
    assign w_second    = r_state == SECOND;
    assign w_split     = (3'(r_addr[1:0]) + f3_size(r_f3)) > 3'd4;
    assign w_shamt     = 6'(r_addr[1:0]) * 6'(BYTE_WIDTH);
    assign w_wdata_win = {32'b0, r_wdata} << w_shamt;
    assign w_be_win    = {4'b0, f3_mask(r_f3)} << r_addr[1:0];
    assign w_base      = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_window    = w_split ? {mem_rdata, r_lo_word} : {32'b0, mem_rdata};

    lsu_extract u_extract (
        .i_window (w_window),
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_f3),
        .o_data   (w_load)
    );

    // All outputs decode registered state/fields only; the wrap past the top word is modular.
    assign req_ready = r_state == IDLE;
    assign mem_req   = w_first || w_second;
    assign mem_we    = mem_req && r_we;
    assign mem_be    = !mem_we ? 4'b0 : w_first ? w_be_win[3:0] : w_be_win[7:4];
    assign mem_addr  = w_first ? w_base : w_second ? w_base + ADDRESS_WIDTH'(4) : '0;
    assign mem_wdata = !mem_we ? '0 : w_first ? w_wdata_win[31:0] : w_wdata_win[63:32];
    assign rsp_valid = r_state == DONE || r_state == ERR;
    assign rsp_err   = r_state == ERR;
    assign rsp_rdata = (r_state == DONE && !r_we) ? w_load : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_f3      <= '0;
            r_lo_word <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_we    <= req_we;
                    r_wdata <= req_wdata;
                    r_f3    <= req_funct3;
                    r_state <= f3_legal(req_we, req_funct3) ? FIRST : ERR;
                end
                FIRST: r_state <= w_split ? SECOND : DONE;
                SECOND: begin
                    r_lo_word <= mem_rdata;
                    r_state   <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the CPU memory stage and a word-organised, byte-enabled data memory.
- Accepts one load or store per handshake, with RISC-V funct3 width/sign encoding.
- Handles any byte alignment; an access that crosses a word boundary becomes two word accesses.
- Produces sign- or zero-extended load data and a completion response.

Parameters:
- ADDRESS_WIDTH, 9, byte-address width of the data memory.
- DATA_WIDTH, 32, word width. Fixed at 32; other values unsupported.
- BYTE_WIDTH, 8, bits per byte lane.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDRESS_WIDTH  byte address
- req_wdata  input  32  store data, right-justified
- req_funct3  input  3  RISC-V funct3 (lb/lh/lw/lbu/lhu; sb/sh/sw)
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  qualifies rsp_valid: unsupported funct3
- rsp_rdata  output  32  extended load data, valid with rsp_valid on a load
- mem_req  output  1  memory access this cycle
- mem_we  output  1  write strobe
- mem_be  output  4  byte-lane enables for writes
- mem_addr  output  ADDRESS_WIDTH  word-aligned byte address (low 2 bits 0)
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  read data for the word addressed in the previous cycle

Behaviour:
- Reset (RST high at an edge) forces state IDLE and clears every registered output to 0.
  - After reset: req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Handshake: a request is accepted on an edge where req_valid and req_ready are both high. The acceptance cycle is T.
  - On acceptance, addr, we, wdata and funct3 are registered.
  - Inputs are ignored outside IDLE.
- Offset is addr[1:0]. Size is 1, 2 or 4 bytes from funct3.
- Split condition: offset + size > 4, i.e. lh/lhu/sh at offset 3, or lw/sw at offset 1, 2 or 3.
- States:
  - IDLE: wait for a handshake. Legal funct3 goes to FIRST; illegal funct3 goes to ERR.
  - FIRST (T+1): mem_req=1, mem_addr = {addr[AW-1:2], 2'b00}. Next state is SECOND if split, else DONE.
  - SECOND (T+2, split only): mem_req=1, mem_addr = first word address + 4, modulo 2^ADDRESS_WIDTH (wraps). mem_rdata (first word) is latched into lo_word. Next state DONE.
  - DONE: rsp_valid=1 for one cycle, then IDLE.
    - Load, unsplit: extract from mem_rdata.
    - Load, split: extract from {mem_rdata, lo_word} as a 64-bit window.
    - Store: rsp_rdata=0.
  - ERR (T+1): rsp_valid=1, rsp_err=1, no memory access, then IDLE.
- Latency from acceptance to rsp_valid:
  - unsplit: 2 cycles (T+2)
  - split: 3 cycles (T+3)
  - error: 1 cycle (T+1)
- Throughput: the next request can be accepted in the cycle following DONE or ERR.
- Store lane steering:
  - Byte mask is 0001, 0011 or 1111 for size 1, 2 or 4.
  - Write data and mask are formed as 64-bit/8-bit windows, shifted left by offset bytes and offset lanes.
  - FIRST uses the low half (mem_be = mask[3:0], mem_wdata = data[31:0]).
  - SECOND uses the high half (mem_be = mask[7:4], mem_wdata = data[63:32]).
  - mem_we=1 in FIRST/SECOND for stores, otherwise 0. mem_be=0 on loads.
- Load extraction:
  - Shift the window right by offset bytes, then take the low size bytes.
  - lb/lh sign-extend from the top extracted bit. lbu/lhu zero-extend. lw passes through.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - All others are errors.
- Reset mid-operation: the next edge returns to IDLE with mem_req/mem_we=0 and no response. A split store interrupted after FIRST leaves only the first half written; this is accepted behaviour.
- Outputs in FIRST/SECOND/DONE/ERR come from registered state and request fields only. There are no combinational paths from req_* to mem_* or rsp_*.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum (IDLE, FIRST, SECOND, DONE, ERR)
  - size and mask helper functions
- Sub-module lsu_extract: combinational 64-bit window, offset, funct3 -> 32-bit extended load data. Unit-testable alone.

Test Plan:
- Preload 0x10=0x88776655 and 0x14=0xCCBBAA99, then lw at 0x10 -> single access at 0x10; rsp_valid at T+2; rsp_rdata=0x88776655.
- lb at 0x13 -> rsp_rdata=0xFFFFFF88. lbu at 0x13 -> 0x00000088. lhu at 0x12 -> 0x00008877. Each unsplit, T+2.
- lh at 0x13 -> mem_addr 0x10 in T+1, 0x14 in T+2; rsp at T+3 with rdata=0xFFFF9988.
- sw 0xDEADBEEF at 0x12:
  - T+1: addr 0x10, be=1100, wdata=0xBEEF0000.
  - T+2: addr 0x14, be=0011, wdata=0x0000DEAD.
  - rsp at T+3; readback lw at 0x12 returns 0xDEADBEEF.
- lw at 0x1FE with ADDRESS_WIDTH=9 -> mem_addr 0x1FC then wraps to 0x000. Load with funct3=011 -> T+1 rsp_valid=1, rsp_err=1, mem_req never high.
- RST asserted in SECOND of a split sh -> next cycle mem_req=0, req_ready=1, no rsp_valid; a following aligned lw completes normally at T+2.
